// File: rtl/imc_pkg.sv
// Shared types for the in-memory-compute dot-product engine.
`default_nettype none

package imc_pkg;

  localparam int N_LANES = 4;

  typedef logic [1:0] lane_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/imc_weight_regs.sv
// Four-entry weight register file; write strobe is pre-qualified by the parent.
`default_nettype none

module imc_weight_regs
  import imc_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 wr_en,
  input  lane_t                                wr_addr,
  input  logic [DATA_WIDTH-1:0]                wr_data,
  output logic [N_LANES-1:0][DATA_WIDTH-1:0]   rd_data
);

  logic [DATA_WIDTH-1:0] regs [N_LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LANES; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_rd
    assign rd_data[g] = regs[g];
  end

endmodule

`default_nettype wire

// File: rtl/imc_dot_engine.sv
// Signed 4-lane dot product against stored weights, one MAC per cycle,
// result held behind a valid/accept handshake.
`default_nettype none

module imc_dot_engine
  import imc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+2,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] dataIna,
  input  logic [DATA_WIDTH-1:0] dataInb,
  input  logic [DATA_WIDTH-1:0] dataInc,
  input  logic [DATA_WIDTH-1:0] dataInd,
  input  logic                  start,
  output logic                  ready,
  input  logic                  wEn,
  input  logic [1:0]            wAddr,
  input  logic [DATA_WIDTH-1:0] wData,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  resValid,
  input  logic                  resAccept,
  output logic [CNT_WIDTH-1:0]  opCount
);

  localparam int PROD_WIDTH = 2*DATA_WIDTH;

  state_t                              state, state_nxt;
  logic [N_LANES-1:0][DATA_WIDTH-1:0]  ops;
  logic [N_LANES-1:0][DATA_WIDTH-1:0]  weights;
  lane_t                               idx;
  logic signed [ACC_WIDTH-1:0]         acc;
  logic [CNT_WIDTH-1:0]                op_cnt;
  logic signed [PROD_WIDTH-1:0]        prod;
  logic signed [ACC_WIDTH-1:0]         prod_ext;
  logic                                wr_en_idle;

  // Weights only change while idle so an operation always sees a stable set.
  assign wr_en_idle = wEn && (state == IDLE);

  imc_weight_regs #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_weights (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en_idle),
    .wr_addr (wAddr),
    .wr_data (wData),
    .rd_data (weights)
  );

  assign prod     = $signed(ops[idx]) * $signed(weights[idx]);
  assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    resValid  = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = MAC;
      end
      MAC: begin
        if (idx == 2'd3) state_nxt = HOLD;
      end
      HOLD: begin
        resValid = 1'b1;
        if (resAccept) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ops    <= '0;
      idx    <= '0;
      acc    <= '0;
      op_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        ops <= {dataInd, dataInc, dataInb, dataIna};
        acc <= '0;
        idx <= '0;
      end
      if (state == MAC) begin
        acc <= acc + prod_ext;
        idx <= idx + 2'd1;
      end
      if (state == HOLD && resAccept) op_cnt <= op_cnt + 1'b1;
    end
  end

  assign result  = (state == HOLD) ? acc : '0;
  assign opCount = op_cnt;

endmodule

`default_nettype wire

// File: tb/tb_imc_dot_engine.sv
// Directed bench for imc_dot_engine with a result scoreboard and reference weight model.
`default_nettype none

module tb_imc_dot_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] dataIna, dataInb, dataInc, dataInd;
  logic        start;
  logic        ready;
  logic        wEn;
  logic [1:0]  wAddr;
  logic [15:0] wData;
  logic [33:0] result;
  logic        resValid;
  logic        resAccept;
  logic [7:0]  opCount;

  imc_dot_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .dataIna   (dataIna),
    .dataInb   (dataInb),
    .dataInc   (dataInc),
    .dataInd   (dataInd),
    .start     (start),
    .ready     (ready),
    .wEn       (wEn),
    .wAddr     (wAddr),
    .wData     (wData),
    .result    (result),
    .resValid  (resValid),
    .resAccept (resAccept),
    .opCount   (opCount)
  );

  always #5 clk = ~clk;

  int          n_err    = 0;
  int          n_checks = 0;
  logic [15:0] mw [4];
  logic [7:0]  mcount;
  logic [33:0] exp_q [$];
  logic [33:0] held;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_w(input logic [1:0] a, input logic [15:0] d);
    wEn = 1'b1; wAddr = a; wData = d;
    step();
    wEn = 1'b0;
    mw[a] = d;
  endtask

  // Drive one operation up to HOLD and check latency and the scoreboarded result.
  task automatic launch(input logic [15:0] a, b, c, d,
                        input logic we, input logic [1:0] wa, input logic [15:0] wd,
                        input bit mid_wr);
    logic [15:0] o [4];
    longint      s;
    if (we) mw[wa] = wd;
    o = '{a, b, c, d};
    s = 0;
    for (int i = 0; i < 4; i++) s += longint'($signed(o[i])) * longint'($signed(mw[i]));
    exp_q.push_back(s[33:0]);
    dataIna = a; dataInb = b; dataInc = c; dataInd = d;
    start = 1'b1; wEn = we; wAddr = wa; wData = wd;
    step();
    start = 1'b0; wEn = 1'b0;
    chk("busy_e0", ready, 0);
    for (int i = 1; i < 4; i++) begin
      if (mid_wr && i == 1) begin
        wEn = 1'b1; wAddr = 2'd1; wData = 16'd50;
      end
      step();
      wEn = 1'b0;
      chk("busy_mac", ready, 0);
      chk("valid_early", resValid, 0);
    end
    step();
    chk("valid_e4", resValid, 1);
    chk("ready_hold", ready, 0);
    if (exp_q.size() == 0) begin
      n_checks++; n_err++;
      $error("FAIL scoreboard: observed=empty expected=entry");
    end else begin
      held = exp_q.pop_front();
      chk("result", result, held);
    end
  endtask

  task automatic accept();
    resAccept = 1'b1;
    step();
    resAccept = 1'b0;
    mcount++;
    chk("ready_after_acc", ready, 1);
    chk("valid_after_acc", resValid, 0);
    chk("result_idle", result, 0);
    chk("opcount", opCount, mcount);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; wEn = 1'b0; wAddr = '0; wData = '0; resAccept = 1'b0;
    dataIna = '0; dataInb = '0; dataInc = '0; dataInd = '0;
    for (int i = 0; i < 4; i++) mw[i] = '0;
    mcount = '0;
    step(); step();
    chk("rst_ready", ready, 1);
    chk("rst_valid", resValid, 0);
    chk("rst_result", result, 0);
    chk("rst_opcount", opCount, 0);
    rst_n = 1'b1;
    step();

    // Basic
    write_w(0, 16'd1); write_w(1, 16'd2); write_w(2, 16'd3); write_w(3, 16'd4);
    launch(16'd1, 16'd1, 16'd1, 16'd1, 0, 0, 0, 0);
    chk("basic_value", result, 34'd10);
    accept();

    // Signed extremes
    for (int i = 0; i < 4; i++) write_w(2'(i), 16'h8000);
    launch(16'h8000, 16'h8000, 16'h8000, 16'h8000, 0, 0, 0, 0);
    chk("extreme_value", result, 34'h1_0000_0000);
    accept();
    write_w(0, 16'hFFFF); write_w(1, 16'd2); write_w(2, 16'hFFFD); write_w(3, 16'd4);
    launch(16'd5, 16'd5, 16'd5, 16'd5, 0, 0, 0, 0);
    chk("mixed_sign", result, 34'd10);
    accept();

    // Backpressure: start and weight writes while holding must be ignored
    launch(16'd2, 16'd3, 16'd4, 16'd5, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      start = i[0]; wEn = ~i[0]; wAddr = 2'd0; wData = 16'd99;
      dataIna = 16'd9; dataInb = 16'd9; dataInc = 16'd9; dataInd = 16'd9;
      step();
      chk("bp_valid", resValid, 1);
      chk("bp_result", result, held);
      chk("bp_ready", ready, 0);
    end
    start = 1'b0; wEn = 1'b0;
    accept();
    step();
    chk("bp_no_queue", ready, 1);
    launch(16'd1, 16'd1, 16'd1, 16'd1, 0, 0, 0, 0);
    accept();

    // Weight write on the start edge is used by that op; writes during MAC are dropped
    launch(16'd1, 16'd0, 16'd0, 16'd0, 1, 2'd0, 16'd7, 0);
    chk("same_edge_w", result, 34'd7);
    accept();
    launch(16'd0, 16'd1, 16'd0, 16'd0, 0, 0, 0, 1);
    accept();
    launch(16'd0, 16'd1, 16'd0, 16'd0, 0, 0, 0, 0);
    chk("mac_w_dropped", result, 34'd2);
    accept();

    // Reset mid-operation
    dataIna = 16'd3; dataInb = 16'd3; dataInc = 16'd3; dataInd = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", ready, 1);
    chk("mid_rst_valid", resValid, 0);
    chk("mid_rst_result", result, 0);
    chk("mid_rst_opcount", opCount, 0);
    for (int i = 0; i < 4; i++) mw[i] = '0;
    mcount = '0;
    step();
    rst_n = 1'b1;
    step();
    launch(16'd3, 16'd3, 16'd3, 16'd3, 0, 0, 0, 0);
    chk("zero_weights", result, 34'd0);
    accept();

    // Counter wrap
    for (int n = 0; n < 255; n++) begin
      launch(16'(n), 16'd1, 16'd2, 16'd3, 0, 0, 0, 0);
      accept();
    end
    chk("wrap_zero", opCount, 8'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
